// File: rtl/coef_serializer_pkg.sv
// Shared constants and helpers for the coefficient serializer.
package coef_serializer_pkg;

  localparam int unsigned DEF_BIT_WIDTH = 16;
  localparam int unsigned DEF_N         = 8;

  // Ceiling log2, used to size the element index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/coef_serializer_bank.sv
// One vector bank: N coefficients written together, one read by index.
module coef_bank
  import coef_serializer_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned N         = DEF_N
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [N*BIT_WIDTH-1:0] wdata,
  input  logic [clog2(N)-1:0]    rd_idx,
  output logic [BIT_WIDTH-1:0]   rdata
);

  logic [BIT_WIDTH-1:0] mem [N];

  // Capture a whole vector; contents are data-only and carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned k = 0; k < N; k++) begin
        mem[k] <= wdata[k*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  assign rdata = mem[rd_idx];

endmodule

// File: rtl/coef_serializer.sv
// Ping-pong buffered vector-to-coefficient serializer.
module coef_serializer
  import coef_serializer_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned N         = DEF_N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*BIT_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH-1:0]   out_data,
  output logic [clog2(N)-1:0]    out_index,
  output logic                   out_last
);

  localparam int unsigned IW       = clog2(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N-1);

  logic [1:0]           full_q, full_d;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 we0, we1;
  logic [BIT_WIDTH-1:0] rdata0, rdata1;

  // State register: bank flags, pointers and element counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      idx_q    <= idx_d;
    end
  end

  // Next state: fill on accept, advance/free on pop; both may happen together.
  always_comb begin
    logic accept;
    logic pop;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;
    we0      = 1'b0;
    we1      = 1'b0;
    accept   = in_valid & ~full_q[wr_sel_q];
    pop      = full_q[rd_sel_q] & out_ready;
    if (accept) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
      we0              = ~wr_sel_q;
      we1              = wr_sel_q;
    end
    // Accept and drain never target the same bank: one needs it empty, the other full.
    if (pop) begin
      if (idx_q == IDX_LAST) begin
        idx_d            = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Outputs: decoded purely from registered state, so no input-to-output path.
  always_comb begin
    in_ready  = ~full_q[wr_sel_q];
    out_valid = full_q[rd_sel_q];
    out_data  = rd_sel_q ? rdata1 : rdata0;
    out_index = idx_q;
    out_last  = full_q[rd_sel_q] & (idx_q == IDX_LAST);
  end

  coef_bank #(.BIT_WIDTH(BIT_WIDTH), .N(N)) u_bank0 (
    .clk    (clk),
    .we     (we0),
    .wdata  (in_data),
    .rd_idx (idx_q),
    .rdata  (rdata0)
  );

  coef_bank #(.BIT_WIDTH(BIT_WIDTH), .N(N)) u_bank1 (
    .clk    (clk),
    .we     (we1),
    .wdata  (in_data),
    .rd_idx (idx_q),
    .rdata  (rdata1)
  );

endmodule

// File: tb/tb_coef_serializer.sv
// Directed and scoreboarded checks for coef_serializer.
module tb_coef_serializer;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_index;
  logic           out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coef_serializer #(.BIT_WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] mkvec(input int base, input int step);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(base + step*i);
    return v;
  endfunction

  function automatic logic [W-1:0] elem(input logic [N*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  initial begin
    logic [N*W-1:0] va, vb, vc;
    logic [W-1:0]   q[$];
    logic [W-1:0]   hold_d;
    logic [IW-1:0]  hold_i;
    logic           stall, acc;
    int             sent, got_cnt, cyc, exp_idx;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_out_index", 32'(out_index), 32'(0));
    rst = 1'b0;
    tick();

    // Single vector 0..7, out_ready high.
    va = mkvec(0, 1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = va;
    check("t1_in_ready0", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("t1_valid", 32'(out_valid), 32'(1));
      check("t1_data", 32'(out_data), 32'(k));
      check("t1_index", 32'(out_index), 32'(k));
      check("t1_last", 32'(out_last), 32'(k == N-1));
      check("t1_in_ready", 32'(in_ready), 32'(1));
      tick();
    end
    check("t1_empty", 32'(out_valid), 32'(0));

    // Back-to-back negative then positive vectors, no bubble.
    va = mkvec(-1, -1);
    vb = mkvec(100, 1);
    in_valid = 1'b1; in_data = va;
    tick();
    in_data = vb;
    check("t2_first_ffff", 32'(out_data), 32'(16'hFFFF));
    for (int k = 0; k < 2*N; k++) begin
      check("t2_valid", 32'(out_valid), 32'(1));
      check("t2_data", 32'(out_data), 32'(k < N ? elem(va, k) : elem(vb, k-N)));
      tick();
      if (k == 0) in_valid = 1'b0;
    end
    check("t2_empty", 32'(out_valid), 32'(0));

    // Backpressure: two accepted, third held until a bank frees.
    va = mkvec(10, 10);
    vb = mkvec(200, 1);
    vc = mkvec(-100, -1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = va;
    tick();
    in_data = vb;
    check("t3_ready_second", 32'(in_ready), 32'(1));
    tick();
    in_data = vc;
    for (int k = 0; k < 3; k++) begin
      check("t3_full_ready", 32'(in_ready), 32'(0));
      check("t3_hold_valid", 32'(out_valid), 32'(1));
      check("t3_hold_data", 32'(out_data), 32'(elem(va, 0)));
      check("t3_hold_index", 32'(out_index), 32'(0));
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3*N; k++) begin
      check("t3_valid", 32'(out_valid), 32'(1));
      check("t3_data", 32'(out_data),
            32'(k < N ? elem(va, k) : (k < 2*N ? elem(vb, k-N) : elem(vc, k-2*N))));
      if (k < N) check("t3_ready_blocked", 32'(in_ready), 32'(0));
      if (k == N) check("t3_ready_freed", 32'(in_ready), 32'(1));
      tick();
      if (k == N) in_valid = 1'b0;
    end
    check("t3_empty", 32'(out_valid), 32'(0));

    // Random backpressure and random vectors against a queue.
    sent = 0; got_cnt = 0; cyc = 0; exp_idx = 0; stall = 1'b0;
    hold_d = '0; hold_i = '0;
    for (int i = 0; i < N; i++) vc[i*W +: W] = W'($urandom);
    in_valid = 1'b1; in_data = vc; out_ready = 1'b0;
    while ((sent < 6 || q.size() != 0) && cyc < 2000) begin
      if (stall) begin
        check("rand_hold_valid", 32'(out_valid), 32'(1));
        check("rand_hold_data", 32'(out_data), 32'(hold_d));
        check("rand_hold_index", 32'(out_index), 32'(hold_i));
      end
      acc = in_valid && in_ready;
      if (acc) begin
        for (int i = 0; i < N; i++) q.push_back(elem(in_data, i));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rand_sb_empty", 32'(0), 32'(1));
        else check("rand_stream", 32'(out_data), 32'(q.pop_front()));
        check("rand_index", 32'(out_index), 32'(exp_idx));
        check("rand_last", 32'(out_last), 32'(exp_idx == N-1));
        exp_idx = (exp_idx + 1) % N;
        got_cnt++;
      end
      stall  = out_valid && !out_ready;
      hold_d = out_data;
      hold_i = out_index;
      tick();
      cyc++;
      if (acc) for (int i = 0; i < N; i++) vc[i*W +: W] = W'($urandom);
      in_valid  = (sent < 6) && ($urandom_range(0, 3) != 0);
      in_data   = vc;
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    check("rand_timeout", 32'(cyc < 2000), 32'(1));
    check("rand_count", 32'(got_cnt), 32'(6*N));
    tick();
    check("rand_empty", 32'(out_valid), 32'(0));

    // Mid-stream reset discards both banks.
    va = mkvec(1000, 3);
    vb = mkvec(-500, 7);
    vc = mkvec(30000, -9);
    out_ready = 1'b1; in_valid = 1'b1; in_data = va;
    tick();
    in_data = vb;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("t5_pre_index", 32'(out_index), 32'(4));
    check("t5_pre_data", 32'(out_data), 32'(elem(va, 4)));
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'(0));
    check("t5_rst_ready", 32'(in_ready), 32'(1));
    check("t5_rst_index", 32'(out_index), 32'(0));
    tick();
    rst = 1'b0;
    tick();
    check("t5_discarded", 32'(out_valid), 32'(0));
    in_valid = 1'b1; in_data = vc;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("t5_valid", 32'(out_valid), 32'(1));
      check("t5_data", 32'(out_data), 32'(elem(vc, k)));
      check("t5_index", 32'(out_index), 32'(k));
      tick();
    end
    check("t5_empty", 32'(out_valid), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coef_serializer.md
COEF_SERIALIZER -- requirements
Module: coef_serializer

Interface
REQ-001 Parameter BIT_WIDTH, default 16: width of one signed coefficient.
REQ-002 Parameter N, default 8: coefficients per input vector; power of two, 2..16.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream vector valid.
REQ-006 in_ready  output  1  block can accept a vector this cycle.
REQ-007 in_data  input  N*BIT_WIDTH  packed signed vector; element k at bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-008 out_valid  output  1  out_data holds a valid coefficient.
REQ-009 out_ready  input  1  downstream accepts the coefficient.
REQ-010 out_data  output  BIT_WIDTH  signed coefficient.
REQ-011 out_index  output  log2(N)  element index of out_data within its vector.
REQ-012 out_last  output  1  high with out_valid when out_index = N-1.

Function
REQ-013 The block SHALL hold two vector banks (ping-pong), each with a registered full flag.
REQ-014 Bank selection SHALL use two registered 1-bit pointers: wr_sel for writes and rd_sel for reads.
REQ-015 in_ready SHALL equal NOT full[wr_sel] and SHALL be driven from registered state only.
REQ-016 On in_valid AND in_ready: store in_data into bank[wr_sel], set full[wr_sel], toggle wr_sel.
REQ-017 out_valid SHALL equal full[rd_sel].
REQ-018 out_data SHALL equal element idx of bank[rd_sel], where idx is a registered counter.
REQ-019 out_index SHALL equal idx.
REQ-020 On out_valid AND out_ready with idx < N-1: idx increments.
REQ-021 On out_valid AND out_ready with idx = N-1: idx becomes 0, full[rd_sel] clears, rd_sel toggles.
REQ-022 Elements SHALL be emitted in order 0..N-1; no reordering, no arithmetic, sign preserved bit-exact.
REQ-023 out_data, out_index and out_last SHALL remain stable while out_valid AND NOT out_ready.
REQ-024 Latency: a vector accepted at edge t SHALL present element 0 with out_valid high after edge t (cycle t+1), provided the other bank is empty.
REQ-025 Accepting a vector and completing a drain in the same cycle SHALL both take effect.
REQ-026 A bank freed at edge t SHALL NOT be writable before cycle t+1; no combinational ready path.
REQ-027 With both banks full, in_ready SHALL be 0 and the input SHALL be ignored.
REQ-028 Sustained throughput SHALL be one coefficient per cycle with a vector offered every N cycles and out_ready held high.
REQ-029 Occupancy SHALL be derivable as EMPTY (0 full), ONE (1 full) or TWO (2 full); no other state is legal.

Reset
REQ-030 While rst is high: full[*]=0, wr_sel=0, rd_sel=0, idx=0.
REQ-031 Consequently in_ready=1, out_valid=0 and out_last=0; out_index=0.
REQ-032 Bank contents need not reset.
REQ-033 Asserting rst mid-stream SHALL discard all buffered vectors; streaming resumes from bank 0, element 0, after release.

Structure
REQ-034 A shared package SHALL define the default BIT_WIDTH and N constants and an index-width function clog2(N).
REQ-035 One sub-module SHALL be used: coef_bank, an N x BIT_WIDTH register bank with write enable; it is instantiated twice.

Verification
REQ-036 Reset then one vector {0,1,...,7}, out_ready=1 -> out_data 0..7 on consecutive cycles starting at cycle t+1; out_last only with 7; in_ready=1 throughout.
REQ-037 Back-to-back vectors A={-1..-8} and B={100..107}, out_ready=1 -> 16 contiguous outputs A then B with no bubble; sign preserved (0xFFFF first).
REQ-038 out_ready=0 with three vectors offered -> two are accepted, in_ready drops, the third is held; out_data stays at element 0 of the first.
REQ-039 Random out_ready at 50 % with random vectors -> output stream equals the input stream in order; no loss and no duplication.
REQ-040 rst pulsed after element 3 of a vector -> out_valid=0 next cycle; the next vector restarts at index 0 from bank 0.
